// File: rtl/ram_bist_if.sv
// ram_bist_if -- RAM-side bus between the BIST controller and the 64x8 RAM.
//
// Signals:
//   ram_data        write data
//   ram_write_addr  write address
//   ram_read_addr   read address
//   ram_we          write enable
//   ram_q           registered read data returned by the RAM (1-cycle latency)
//
// Modports:
//   master  the BIST controller (drives write/read port, receives ram_q)
//   slave   the RAM instance
interface ram_bist_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] ram_data;
    logic [ADDR_WIDTH-1:0] ram_write_addr;
    logic [ADDR_WIDTH-1:0] ram_read_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    modport master (
        output ram_data, ram_write_addr, ram_read_addr, ram_we,
        input  ram_q
    );

    modport slave (
        input  ram_data, ram_write_addr, ram_read_addr, ram_we,
        output ram_q
    );
endinterface

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl -- march-test BIST initiator for the 64x8 synchronous RAM.
// Runs W0(up), R0W1(up), R1W0(down), R0(up) on a start pulse and reports
// pass/fail with the first failing address and read data.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a test (honoured only in IDLE or DONE)
//   busy       test running
//   done       test finished, results valid until next start
//   pass       1 = no mismatch (valid while done)
//   fail_addr  address of the first mismatch
//   fail_data  ram_q value at the first mismatch
//   err_count  mismatch count, saturating (only with RAM_BIST_ERR_COUNT_EN)
//   ram        RAM bus (ram_bist_if.master)
//
// Build option: define RAM_BIST_ERR_COUNT_EN to keep running through
// mismatches and count them instead of stopping on the first one.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start after reset
// W0     | write PATTERN, addr ascending, 1 cycle per address
// R0W1   | read expect PATTERN, write ~PATTERN, ascending, RD/CMP
// R1W0   | read expect ~PATTERN, write PATTERN, descending, RD/CMP
// R0     | read expect PATTERN, no write, ascending, RD/CMP
// DONE   | results held until the next start
module ram_bist_ctrl #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h55
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
`ifdef RAM_BIST_ERR_COUNT_EN
    output logic [ADDR_WIDTH+2:0] err_count,
`endif
    ram_bist_if.master            ram
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_W0   = 3'd1;
    localparam logic [2:0] S_R0W1 = 3'd2;
    localparam logic [2:0] S_R1W0 = 3'd3;
    localparam logic [2:0] S_R0   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]            state;
    logic                  phase;          // 0 = RD, 1 = CMP
    logic [ADDR_WIDTH-1:0] addr;

    logic [DATA_WIDTH-1:0] expected;
    logic [DATA_WIDTH-1:0] wr_value;
    logic                  write_in_cmp;
    logic                  cmp_active;
    logic                  mismatch;
    logic                  addr_is_last;
    logic                  stop_now;       // mismatch that ends the run
    logic                  capture_fail;   // mismatch that is the first one
    logic                  pass_final;     // pass value when R0 completes

    always_comb begin
        expected     = PATTERN;
        wr_value     = PATTERN;
        write_in_cmp = 1'b0;
        case (state)
            S_R0W1: begin
                wr_value     = ~PATTERN;
                write_in_cmp = 1'b1;
            end
            S_R1W0: begin
                expected     = ~PATTERN;
                write_in_cmp = 1'b1;
            end
            default: ;
        endcase

        cmp_active   = phase && ((state == S_R0W1) || (state == S_R1W0) || (state == S_R0));
        mismatch     = cmp_active && (ram.ram_q != expected);
        addr_is_last = (state == S_R1W0) ? (addr == '0) : (addr == '1);

`ifdef RAM_BIST_ERR_COUNT_EN
        stop_now     = 1'b0;
        capture_fail = mismatch && (err_count == '0);
        pass_final   = (err_count == '0) && !mismatch;
`else
        stop_now     = mismatch;
        capture_fail = mismatch;
        pass_final   = 1'b1;
`endif

        // The CMP write is dropped when the mismatch ends the run, so the
        // faulty cell keeps the value that exposed it.
        ram.ram_we = (state == S_W0) || (cmp_active && write_in_cmp && !stop_now);
        ram.ram_data       = ram.ram_we ? wr_value : '0;
        ram.ram_write_addr = addr;
        ram.ram_read_addr  = addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase     <= 1'b0;
            addr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
`ifdef RAM_BIST_ERR_COUNT_EN
            err_count <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_W0;
                        phase     <= 1'b0;
                        addr      <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
`ifdef RAM_BIST_ERR_COUNT_EN
                        err_count <= '0;
`endif
                    end
                end
                S_W0: begin
                    if (addr_is_last) begin
                        addr  <= '0;
                        state <= S_R0W1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                S_R0W1, S_R1W0, S_R0: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (capture_fail) begin
                            fail_addr <= addr;
                            fail_data <= ram.ram_q;
                        end
`ifdef RAM_BIST_ERR_COUNT_EN
                        if (mismatch && (err_count != '1))
                            err_count <= err_count + 1'b1;
`endif
                        if (stop_now) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b0;
                        end else if (addr_is_last) begin
                            case (state)
                                S_R0W1: begin
                                    state <= S_R1W0;
                                    addr  <= '1;
                                end
                                S_R1W0: begin
                                    state <= S_R0;
                                    addr  <= '0;
                                end
                                default: begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    pass  <= pass_final;
                                end
                            endcase
                        end else if (state == S_R1W0) begin
                            addr <= addr - 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Built-in self-test initiator for the team's 64x8 synchronous RAM. It drives the RAM's write port and read port and checks the RAM's registered read data.
- Runs a 4-element march test (W0 up, R0W1 up, R1W0 down, R0 up) when `start` is pulsed, then reports pass/fail and the first failing address and data.
- Sits between the test/debug logic and the RAM instance. It is the client-side counterpart of the RAM.

Parameters:
- ADDR_WIDTH, 6, RAM address width; depth N = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width.
- PATTERN, 8'h55, background data written in W0; the inverse (~PATTERN) is the "1" background.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin test; sampled only in IDLE or DONE
- busy  out  1  high while a test is running
- done  out  1  high from test completion until next start
- pass  out  1  valid while done=1; 1 = no mismatch
- fail_addr  out  ADDR_WIDTH  address of first mismatch
- fail_data  out  DATA_WIDTH  ram_q value at first mismatch
- ram_data  out  DATA_WIDTH  RAM write data
- ram_write_addr  out  ADDR_WIDTH  RAM write address
- ram_read_addr  out  ADDR_WIDTH  RAM read address
- ram_we  out  1  RAM write enable
- ram_q  in  DATA_WIDTH  RAM registered read data (1-cycle latency)

Behaviour:
- Reset values: busy=0, done=0, pass=0, fail_addr=0, fail_data=0, ram_we=0, ram_data=0, both addresses=0; state=IDLE.
- Reset asserted mid-test aborts immediately: ram_we drops asynchronously and the block returns to IDLE.
- States: IDLE, W0, R0W1, R1W0, R0, DONE.
- Single address counter `addr`, which drives both ram_read_addr and ram_write_addr.
- start=1 in IDLE/DONE at edge E0:
  - busy=1, done=0, pass=0, fail_* cleared, addr=0, state=W0.
  - start is ignored while busy.
- W0:
  - 1 cycle per address, ram_we=1, ram_data=PATTERN.
  - addr counts 0..N-1; at N-1 it goes to R0W1 with addr=0.
- Read-modify elements take 2 cycles per address:
  - RD phase: ram_we=0 (read issued).
  - CMP phase: ram_q is compared against the expected value, and ram_we=1 writes the new value to the same addr.
  - ram_q is sampled only in CMP phases.
  - Write-through during the CMP write is never sampled.
- R0W1: expect PATTERN, write ~PATTERN; addr ascending 0..N-1.
- R1W0: expect ~PATTERN, write PATTERN; addr descending N-1..0 (starts at N-1, no wrap).
- R0: RD/CMP with no write (ram_we=0 in both phases), expect PATTERN, ascending.
- Fault-free run length:
  - N + 3*2N = 7N cycles of test activity (448 for N=64).
  - Last compare happens in cycle E448, so done=1 and pass=1 from E449.
- Mismatch in a CMP phase (default build):
  - fail_addr=addr and fail_data=ram_q are captured.
  - The write for that CMP phase is suppressed (ram_we=0).
  - Next cycle: state=DONE, busy=0, done=1, pass=0.
- DONE holds all results until start. start in DONE restarts exactly as from IDLE.
- Counter wrap: the addr increment/decrement is never allowed to wrap inside an element; element transitions are taken on terminal count.

Optional Feature:
- Macro: RAM_BIST_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [ADDR_WIDTH+2:0] (reset 0, cleared on start).
  - Mismatches do not stop the test. Each mismatch increments err_count, saturating at all-ones.
  - The CMP write still occurs.
  - fail_addr/fail_data capture only the first mismatch.
  - The run always takes 448 cycles; pass = (err_count==0).
- Undefined:
  - err_count port and counter are absent.
  - The block stops on the first mismatch as described in Behaviour.

Test Plan:
- Fault-free RAM model, start pulse at E0 -> ram_we=1 with data 8'h55 at addresses 0..63 in E1..E64; done=1, pass=1 at E449; busy low from E449.
- RAM model with bit3 stuck-at-1 at address 0x2A -> first mismatch in R0W1 at addr 0x2A; done=1, pass=0, fail_addr=6'h2A, fail_data=8'h5D; no write to 0x2A in that CMP cycle.
- Monitor addresses during R1W0 -> ram_read_addr sequence 63,63,62,62,...,0,0; ram_data=8'h55 on every we=1 cycle in that element.
- start re-pulsed at cycle 50 while busy -> ignored, completion still at E449; start pulsed in DONE -> done=0, fresh 448-cycle run, pass=1.
- rst_n low at cycle 100 for 2 cycles -> ram_we=0, busy=0, done=0 immediately; after release, start -> full passing run.
- With RAM_BIST_ERR_COUNT_EN and bit3 stuck-at-1 at 0x05 and 0x30 -> run completes at E449, err_count=4, pass=0, fail_addr=6'h05, fail_data=8'h5D.
